// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// combinational lookup/resolution ports and saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [STAT_W-1:0] br_count_o,
  output logic [STAT_W-1:0] mispred_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (&c) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
    return (&s) ? s : s + STAT_W'(1);
  endfunction

  logic              btb_valid [ENTRIES];
  logic [TAG_W-1:0]  btb_tag   [ENTRIES];
  logic [ADDR_W-1:0] btb_tgt   [ENTRIES];
  logic [CTR_W-1:0]  btb_ctr   [ENTRIES];
  logic [STAT_W-1:0] br_cnt;
  logic [STAT_W-1:0] mis_cnt;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_en;

  // Lookup path: reads registered table state only, so no same-cycle bypass from the update port
  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

  assign pred_taken_o  = start_i && lk_hit && btb_ctr[lk_idx][CTR_W-1];
  assign pred_target_o = pred_taken_o ? btb_tgt[lk_idx] : lookup_pc_i + PC_STEP;

  assign upd_en  = upd_valid_i && start_i;
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  assign mispredict_o = upd_en &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && (upd_pred_target_i != upd_target_i)));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + PC_STEP;

  assign br_count_o      = br_cnt;
  assign mispred_count_o = mis_cnt;

  // Table and statistics update at the resolving edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_tag[i]   <= '0;
        btb_tgt[i]   <= '0;
        btb_ctr[i]   <= CTR_WEAK_NT;
      end
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        btb_ctr[upd_idx] <= upd_taken_i ? ctr_inc(btb_ctr[upd_idx]) : ctr_dec(btb_ctr[upd_idx]);
        if (upd_taken_i) begin
          btb_tgt[upd_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        btb_valid[upd_idx] <= 1'b1;
        btb_tag[upd_idx]   <= upd_tag;
        btb_tgt[upd_idx]   <= upd_target_i;
        btb_ctr[upd_idx]   <= CTR_WEAK_T;
      end
      br_cnt <= stat_inc(br_cnt);
      if (mispredict_o) begin
        mis_cnt <= stat_inc(mis_cnt);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic against an array-based model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;

  logic        pred_taken, pred_taken4;
  logic [31:0] pred_target, pred_target4;
  logic        mispredict, mispredict4;
  logic [31:0] redirect_pc, redirect_pc4;
  logic [15:0] br_count, mispred_count;
  logic [3:0]  br_count4, mispred_count4;

  int vectors = 0;
  int miscompares = 0;

  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int          m_br;
  int          m_mis;

  branch_predictor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .lookup_pc_i(lookup_pc),
    .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .mispredict_o(mispredict),
    .redirect_pc_o(redirect_pc), .br_count_o(br_count), .mispred_count_o(mispred_count)
  );

  branch_predictor #(.STAT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .lookup_pc_i(lookup_pc),
    .pred_taken_o(pred_taken4), .pred_target_o(pred_target4),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .mispredict_o(mispredict4),
    .redirect_pc_o(redirect_pc4), .br_count_o(br_count4), .mispred_count_o(mispred_count4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int cap(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_br = 0;
    m_mis = 0;
  endtask

  function automatic bit model_taken(logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return start && m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_target(logic [31:0] pc);
    return model_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit model_mispredict();
    return upd_valid && start &&
           ((upd_taken != upd_pred_taken) || (upd_taken && (upd_pred_target != upd_target)));
  endfunction

  task automatic model_commit();
    int i;
    bit hit;
    if (rst || !(upd_valid && start)) return;
    i = idx_of(upd_pc);
    hit = m_valid[i] && (m_tag[i] == (upd_pc >> 6));
    m_br++;
    if (model_mispredict()) m_mis++;
    if (hit) begin
      if (upd_taken) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = upd_target;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (upd_taken) begin
      m_valid[i] = 1'b1; m_tag[i] = upd_pc >> 6; m_target[i] = upd_target; m_ctr[i] = 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic set_upd(logic v, logic [31:0] pc, logic t, logic [31:0] tgt,
                         logic pt, logic [31:0] ptgt);
    upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
    return 32'h1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; lookup_pc = 32'h100;
    set_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
    vectors++; if (pred_target !== 32'h104) begin miscompares++; $display("FAIL reset_pred_target got %0h want 104", pred_target); end
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL reset_mispredict got %0b want 0", mispredict); end
    vectors++; if (br_count !== 16'd0 || mispred_count !== 16'd0) begin miscompares++; $display("FAIL reset_stats got %0d/%0d want 0/0", br_count, mispred_count); end
    vectors++; if (br_count4 !== 4'd0 || mispred_count4 !== 4'd0) begin miscompares++; $display("FAIL reset_stats4 got %0d/%0d want 0/0", br_count4, mispred_count4); end
  endtask

  task automatic test_allocate();
    set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    #1;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL alloc_mispredict got %0b want 1", mispredict); end
    vectors++; if (redirect_pc !== 32'h200) begin miscompares++; $display("FAIL alloc_redirect got %0h want 200", redirect_pc); end
    tick();
    upd_valid = 1'b0;
    #1;
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin miscompares++; $display("FAIL alloc_lookup got %0b/%0h want 1/200", pred_taken, pred_target); end
    vectors++; if (br_count !== 16'd1 || mispred_count !== 16'd1) begin miscompares++; $display("FAIL alloc_stats got %0d/%0d want 1/1", br_count, mispred_count); end
  endtask

  task automatic test_counter();
    bit          tk  [5];
    bit          pt  [5];
    logic [31:0] ptg [5];
    bit          em  [5];
    bit          ept [5];
    tk  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pt  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ptg = '{32'h200, 32'h104, 32'h104, 32'h104, 32'h104};
    em  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ept = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    lookup_pc = 32'h100;
    for (int s = 0; s < 5; s++) begin
      set_upd(1'b1, 32'h100, tk[s], 32'h200, pt[s], ptg[s]);
      #1;
      vectors++; if (mispredict !== em[s] || redirect_pc !== (tk[s] ? 32'h200 : 32'h104)) begin
        miscompares++; $display("FAIL ctr_resolve step %0d got %0b/%0h want %0b/%0h", s, mispredict, redirect_pc, em[s], tk[s] ? 32'h200 : 32'h104);
      end
      tick();
      upd_valid = 1'b0;
      #1;
      vectors++; if (pred_taken !== ept[s] || pred_target !== (ept[s] ? 32'h200 : 32'h104)) begin
        miscompares++; $display("FAIL ctr_lookup step %0d got %0b/%0h want %0b/%0h", s, pred_taken, pred_target, ept[s], ept[s] ? 32'h200 : 32'h104);
      end
    end
    vectors++; if (br_count !== 16'd6 || mispred_count !== 16'd4) begin miscompares++; $display("FAIL ctr_stats got %0d/%0d want 6/4", br_count, mispred_count); end
  endtask

  task automatic test_alias();
    set_upd(1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    #1;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL alias_mispredict got %0b want 1", mispredict); end
    tick();
    upd_valid = 1'b0; lookup_pc = 32'h100;
    #1;
    vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin miscompares++; $display("FAIL alias_evicted got %0b/%0h want 0/104", pred_taken, pred_target); end
    lookup_pc = 32'h140;
    #1;
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin miscompares++; $display("FAIL alias_resident got %0b/%0h want 1/300", pred_taken, pred_target); end
  endtask

  task automatic test_same_cycle();
    set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick();
    lookup_pc = 32'h100;
    set_upd(1'b1, 32'h100, 1'b1, 32'h280, 1'b1, 32'h200);
    #1;
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin miscompares++; $display("FAIL same_cycle_old got %0b/%0h want 1/200", pred_taken, pred_target); end
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 32'h280) begin miscompares++; $display("FAIL target_mispredict got %0b/%0h want 1/280", mispredict, redirect_pc); end
    tick();
    upd_valid = 1'b0;
    #1;
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h280) begin miscompares++; $display("FAIL same_cycle_new got %0b/%0h want 1/280", pred_taken, pred_target); end
    vectors++; if (br_count !== 16'd9 || mispred_count !== 16'd7) begin miscompares++; $display("FAIL same_cycle_stats got %0d/%0d want 9/7", br_count, mispred_count); end
  endtask

  task automatic test_start_low();
    start = 1'b0; lookup_pc = 32'h100;
    set_upd(1'b1, 32'h100, 1'b1, 32'h3F0, 1'b0, 32'h104);
    #1;
    vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin miscompares++; $display("FAIL start_low_pred got %0b/%0h want 0/104", pred_taken, pred_target); end
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL start_low_mispredict got %0b want 0", mispredict); end
    tick();
    start = 1'b1; upd_valid = 1'b0;
    #1;
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h280) begin miscompares++; $display("FAIL start_low_hold got %0b/%0h want 1/280", pred_taken, pred_target); end
    vectors++; if (br_count !== 16'd9 || mispred_count !== 16'd7) begin miscompares++; $display("FAIL start_low_stats got %0d/%0d want 9/7", br_count, mispred_count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 15) != 0);
      lookup_pc = rand_pc();
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_pc = rand_pc();
      upd_taken = 1'($urandom_range(0, 1));
      upd_target = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        upd_pred_taken = model_taken(upd_pc);
        upd_pred_target = model_target(upd_pc);
      end else begin
        upd_pred_taken = 1'($urandom_range(0, 1));
        upd_pred_target = 32'($urandom_range(0, 1023)) << 2;
      end
      #1;
      vectors++; if (pred_taken !== model_taken(lookup_pc) || pred_target !== model_target(lookup_pc)) begin
        miscompares++; $display("FAIL rand_lookup n=%0d pc=%0h got %0b/%0h want %0b/%0h", n, lookup_pc, pred_taken, pred_target, model_taken(lookup_pc), model_target(lookup_pc));
      end
      vectors++; if (mispredict !== model_mispredict()) begin
        miscompares++; $display("FAIL rand_mispredict n=%0d got %0b want %0b", n, mispredict, model_mispredict());
      end
      if (upd_valid) begin
        vectors++; if (redirect_pc !== (upd_taken ? upd_target : upd_pc + 32'd4)) begin
          miscompares++; $display("FAIL rand_redirect n=%0d got %0h want %0h", n, redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
        end
      end
      vectors++; if (br_count !== 16'(cap(m_br, 65535)) || mispred_count !== 16'(cap(m_mis, 65535))) begin
        miscompares++; $display("FAIL rand_stats n=%0d got %0d/%0d want %0d/%0d", n, br_count, mispred_count, m_br, m_mis);
      end
      vectors++; if (br_count4 !== 4'(cap(m_br, 15)) || mispred_count4 !== 4'(cap(m_mis, 15))) begin
        miscompares++; $display("FAIL rand_stats4 n=%0d got %0d/%0d want %0d/%0d", n, br_count4, mispred_count4, cap(m_br, 15), cap(m_mis, 15));
      end
      tick();
    end
  endtask

  task automatic test_stat_sat();
    rst = 1'b1; upd_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_upd(1'b1, 32'h2000 + 32'(i * 4), 1'b1, 32'h3000 + 32'(i * 4), 1'b0, 32'h0);
      tick();
    end
    upd_valid = 1'b0;
    #1;
    vectors++; if (br_count4 !== 4'd15 || mispred_count4 !== 4'd15) begin miscompares++; $display("FAIL stat_sat4 got %0d/%0d want 15/15", br_count4, mispred_count4); end
    vectors++; if (br_count !== 16'd20 || mispred_count !== 16'd20) begin miscompares++; $display("FAIL stat_nosat got %0d/%0d want 20/20", br_count, mispred_count); end
  endtask

  task automatic test_async_reset();
    lookup_pc = 32'h2010;
    #1;
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h3010) begin miscompares++; $display("FAIL pre_reset_lookup got %0b/%0h want 1/3010", pred_taken, pred_target); end
    set_upd(1'b1, 32'h504, 1'b1, 32'h700, 1'b0, 32'h508);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++; if (br_count4 !== 4'd0 || mispred_count4 !== 4'd0 || br_count !== 16'd0) begin miscompares++; $display("FAIL async_stats got %0d/%0d/%0d want 0/0/0", br_count4, mispred_count4, br_count); end
    vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h2014) begin miscompares++; $display("FAIL async_btb got %0b/%0h want 0/2014", pred_taken, pred_target); end
    tick();
    rst = 1'b0;
    set_upd(1'b1, 32'h548, 1'b1, 32'h600, 1'b0, 32'h54C);
    #1;
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL post_reset_mispredict got %0b want 1", mispredict); end
    tick();
    upd_valid = 1'b0; lookup_pc = 32'h504;
    #1;
    vectors++; if (pred_taken !== 1'b0 || pred_target !== 32'h508) begin miscompares++; $display("FAIL discarded_update got %0b/%0h want 0/508", pred_taken, pred_target); end
    lookup_pc = 32'h548;
    #1;
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h600) begin miscompares++; $display("FAIL first_update got %0b/%0h want 1/600", pred_taken, pred_target); end
    vectors++; if (br_count !== 16'd1 || mispred_count4 !== 4'd1) begin miscompares++; $display("FAIL post_reset_stats got %0d/%0d want 1/1", br_count, mispred_count4); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_start_low();
    test_random();
    test_stat_sat();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
